prim_cmd_sequencer: RTL and testbench

PRIM_CMD_SEQUENCER -- requirements
Module: prim_cmd_sequencer

---
 rtl/prim_cmd_sequencer_pkg.sv | 19 +
 rtl/prim_cmd_sequencer_if.sv | 9 +
 rtl/prim_cmd_fifo.sv | 48 ++++
 rtl/prim_cmd_sequencer.sv | 88 ++++++++
 tb/tb_prim_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/prim_cmd_sequencer_pkg.sv
// xv: renderer opcodes, primitive codes and sequencer defaults shared by the
// command sequencer and the blocks around it.
package xv;
  typedef logic [15:0] prim_word_t;
  localparam logic [3:0] PR_NOP     = 4'h0;
  localparam logic [3:0] PR_COORDX0 = 4'h1;
  localparam logic [3:0] PR_COORDY0 = 4'h2;
  localparam logic [3:0] PR_COORDX1 = 4'h3;
  localparam logic [3:0] PR_COORDY1 = 4'h4;
  localparam logic [3:0] PR_COLOR   = 4'h5;
  localparam logic [3:0] PR_EXECUTE = 4'h6;
  localparam logic [11:0] PRIM_LINE = 12'h001;
  localparam logic [11:0] PRIM_RECT = 12'h002;
  localparam int PRSEQ_START_TIMEOUT = 4;
  localparam int PRSEQ_FIFO_DEPTH = 16;
  function automatic logic [3:0] opcode_of(input prim_word_t w);
    return w[15:12];
  endfunction
endpackage

// File: rtl/prim_cmd_sequencer_if.sv
// prim_cmd_sequencer_if: host command write port (valid/ready handshake).
interface prim_cmd_sequencer_if;
  import xv::*;
  prim_word_t cmd;
  logic valid;
  logic ready;
  modport master (output cmd, output valid, input ready);
  modport slave (input cmd, input valid, output ready);
endinterface

// File: rtl/prim_cmd_fifo.sv
// prim_cmd_fifo: register-array command FIFO with push/pop/clear and a level count.
module prim_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  // A write into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
  always_comb begin
    wptr_d  = clear_i ? '0 : wptr_q + AW'(do_push);
    rptr_d  = clear_i ? '0 : rptr_q + AW'(do_pop);
    level_d = clear_i ? '0 : level_q + LW'(do_push) - LW'(do_pop);
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= wdata_i;
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/prim_cmd_sequencer.sv
// prim_cmd_sequencer: buffers host command words and feeds them to the renderer,
// holding off while an EXECUTE'd primitive is starting or drawing.
module prim_cmd_sequencer
  import xv::*;
#(
  parameter int FIFO_DEPTH = PRSEQ_FIFO_DEPTH,
  parameter int START_TIMEOUT = PRSEQ_START_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset_n_i,
  prim_cmd_sequencer_if.slave         host,
  input  logic                        clear_i,
  input  logic                        prim_busy_i,
  output prim_word_t                  prim_cmd_o,
  output logic                        prim_cmd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        overflow_o,
  output logic                        idle_o
);
  localparam int CW = $clog2(START_TIMEOUT + 2);
  typedef logic [1:0] state_t;
  localparam state_t ISSUE      = 2'd0;
  localparam state_t WAIT_START = 2'd1;
  localparam state_t WAIT_DONE  = 2'd2;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  prim_word_t prim_cmd_q, prim_cmd_d, fifo_rdata;
  logic valid_q, valid_d, overflow_q, overflow_d;
  logic fifo_full, fifo_empty, pop, is_exec;

  prim_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .push_i    (host.valid),
    .pop_i     (pop),
    .wdata_i   (host.cmd),
    .rdata_o   (fifo_rdata),
    .level_o   (fifo_level_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Never pop mid-draw: the renderer is still reading the coordinate/colour registers.
  assign pop     = state_q == ISSUE && !fifo_empty && !prim_busy_i && !clear_i;
  assign is_exec = opcode_of(fifo_rdata) == PR_EXECUTE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (state_q == ISSUE) begin
      state_d = (pop && is_exec) ? WAIT_START : ISSUE;
      cnt_d   = (pop && is_exec) ? CW'(START_TIMEOUT) : cnt_q;
    end else if (state_q == WAIT_START) begin
      // Busy never rising (unsupported primitive, zero-length draw) times out back to ISSUE.
      state_d = clear_i ? ISSUE : prim_busy_i ? WAIT_DONE : (cnt_q <= CW'(1)) ? ISSUE : WAIT_START;
      cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    end else begin
      state_d = prim_busy_i ? WAIT_DONE : ISSUE;
    end
    valid_d    = pop;
    prim_cmd_d = pop ? fifo_rdata : prim_cmd_q;
    overflow_d = clear_i ? 1'b0 : (overflow_q | (host.valid & fifo_full));
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ISSUE;
      cnt_q      <= '0;
      prim_cmd_q <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prim_cmd_q <= prim_cmd_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign host.ready       = !fifo_full;
  assign prim_cmd_o       = prim_cmd_q;
  assign prim_cmd_valid_o = valid_q;
  assign overflow_o       = overflow_q;
  assign idle_o           = fifo_empty && state_q == ISSUE && !prim_busy_i;
endmodule

// File: tb/tb_prim_cmd_sequencer.sv
// tb_prim_cmd_sequencer: queue-based reference model with a scoreboard monitor,
// directed scenarios followed by randomized traffic.
module tb_prim_cmd_sequencer;
  import xv::*;
  localparam int DEPTH = 16;
  localparam int T = 4;

  typedef struct { int c; logic [15:0] w; } exp_t;

  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  logic clear_r = 1'b0;
  logic busy_r = 1'b0;
  logic [15:0] prim_cmd_o;
  logic prim_cmd_valid_o, overflow_o, idle_o;
  logic [4:0] fifo_level_o;

  prim_cmd_sequencer_if host_if ();

  prim_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .START_TIMEOUT(T)) dut (
    .clk              (clk),
    .reset_n_i        (reset_n_i),
    .host             (host_if),
    .clear_i          (clear_r),
    .prim_busy_i      (busy_r),
    .prim_cmd_o       (prim_cmd_o),
    .prim_cmd_valid_o (prim_cmd_valid_o),
    .fifo_level_o     (fifo_level_o),
    .overflow_o       (overflow_o),
    .idle_o           (idle_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [15:0] mq[$];
  exp_t exq[$];
  int mode = 0;
  int dl = 0;
  logic ovf = 1'b0;
  logic [15:0] last_cmd = 16'h0;
  int stb_c[$];
  logic [15:0] stb_w[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    exq.delete();
    mode = 0;
    ovf = 1'b0;
    last_cmd = 16'h0;
  endfunction

  // mode: 0 issuing, 1 waiting for busy to rise (deadline dl), 2 waiting for busy to fall
  function automatic void model_edge();
    int sz;
    logic p;
    logic [15:0] w;
    sz = mq.size();
    p = mode == 0 && sz > 0 && !busy_r && !clear_r;
    if (mode == 1) mode = clear_r ? 0 : busy_r ? 2 : (cyc >= dl) ? 0 : 1;
    else if (mode == 2 && !busy_r) mode = 0;
    if (p) begin
      w = mq.pop_front();
      exq.push_back('{c: cyc, w: w});
      if (w[15:12] == PR_EXECUTE) begin
        mode = 1;
        dl = cyc + T;
      end
    end
    if (clear_r) begin
      mq.delete();
      ovf = 1'b0;
    end else if (host_if.valid) begin
      if (sz < DEPTH) mq.push_back(host_if.cmd);
      else ovf = 1'b1;
    end
  endfunction

  task automatic step(input logic v, input logic [15:0] c, input logic cl, input logic b);
    host_if.valid = v;
    host_if.cmd = c;
    clear_r = cl;
    busy_r = b;
    @(posedge clk);
    cyc++;
    model_edge();
    #2;
  endtask

  always @(negedge clk) begin
    logic en;
    exp_t e;
    if (reset_n_i) begin
      en = exq.size() > 0 && exq[0].c == cyc;
      chk("strobe", 32'(prim_cmd_valid_o), 32'(en));
      if (prim_cmd_valid_o) begin
        stb_c.push_back(cyc);
        stb_w.push_back(prim_cmd_o);
      end
      if (en) begin
        e = exq.pop_front();
        chk("cmd", 32'(prim_cmd_o), 32'(e.w));
        last_cmd = e.w;
      end else chk("cmd_hold", 32'(prim_cmd_o), 32'(last_cmd));
      chk("level", 32'(fifo_level_o), 32'(mq.size()));
      chk("overflow", 32'(overflow_o), 32'(ovf));
      chk("ready", 32'(host_if.ready), 32'(mq.size() < DEPTH));
      chk("idle", 32'(idle_o), 32'(mq.size() == 0 && mode == 0 && !busy_r));
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, 32'(prim_cmd_valid_o), 32'd0);
    chk({nm, "_cmd"}, 32'(prim_cmd_o), 32'd0);
    chk({nm, "_level"}, 32'(fifo_level_o), 32'd0);
    chk({nm, "_ready"}, 32'(host_if.ready), 32'd1);
    chk({nm, "_ovf"}, 32'(overflow_o), 32'd0);
    chk({nm, "_idle"}, 32'(idle_o), 32'd1);
  endtask

  initial begin
    int w0;
    int brun;
    logic [3:0] op;
    host_if.valid = 1'b0;
    host_if.cmd = 16'h0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #1 reset_n_i = 1'b1;

    // Single write: strobe exactly two cycles after the write cycle
    stb_c.delete(); stb_w.delete();
    w0 = cyc;
    step(1'b1, {PR_COORDX0, 12'h005}, 1'b0, 1'b0);
    repeat (4) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("single_count", 32'(stb_c.size()), 32'd1);
    if (stb_c.size() == 1) begin
      chk("single_cycle", 32'(stb_c[0]), 32'(w0 + 2));
      chk("single_word", 32'(stb_w[0]), 32'h1005);
    end
    chk("single_idle", 32'(idle_o), 32'd1);

    // Line draw: five back-to-back strobes, trailing word after busy window
    stb_c.delete(); stb_w.delete();
    w0 = cyc;
    step(1'b1, {PR_COORDX0, 12'h010}, 1'b0, 1'b0);
    step(1'b1, {PR_COORDY0, 12'h020}, 1'b0, 1'b0);
    step(1'b1, {PR_COORDX1, 12'h030}, 1'b0, 1'b0);
    step(1'b1, {PR_COORDY1, 12'h040}, 1'b0, 1'b0);
    step(1'b1, {PR_EXECUTE, PRIM_LINE}, 1'b0, 1'b0);
    step(1'b1, {PR_COORDX0, 12'h050}, 1'b0, 1'b0);
    repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 16'h0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("line_count", 32'(stb_c.size()), 32'd6);
    if (stb_c.size() == 6) begin
      chk("line_exec_cycle", 32'(stb_c[4]), 32'(w0 + 6));
      for (int i = 1; i < 5; i++) chk("line_consec", 32'(stb_c[i] - stb_c[i-1]), 32'd1);
      chk("line_trailing", 32'(stb_c[5] - stb_c[4]), 32'd14);
    end

    // Unsupported primitive: start timeout releases the next word
    stb_c.delete(); stb_w.delete();
    step(1'b1, {PR_EXECUTE, 12'h00F}, 1'b0, 1'b0);
    step(1'b1, {PR_COLOR, 12'h0AB}, 1'b0, 1'b0);
    repeat (8) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("timeout_count", 32'(stb_c.size()), 32'd2);
    if (stb_c.size() == 2) chk("timeout_gap", 32'(stb_c[1] - stb_c[0]), 32'(T + 1));

    // Overflow: 17 writes while busy
    for (int i = 0; i < 17; i++) begin
      step(1'b1, {PR_COORDX0, 12'(i)}, 1'b0, 1'b1);
      if (i == 15) chk("full_ready", 32'(host_if.ready), 32'd0);
    end
    chk("full_level", 32'(fifo_level_o), 32'd16);
    chk("full_ovf", 32'(overflow_o), 32'd1);

    // Clear while drawing with three words queued
    step(1'b0, 16'h0, 1'b1, 1'b1);
    stb_c.delete(); stb_w.delete();
    step(1'b1, {PR_EXECUTE, PRIM_RECT}, 1'b0, 1'b0);
    step(1'b1, {PR_COORDX0, 12'h001}, 1'b0, 1'b0);
    step(1'b1, {PR_COORDY0, 12'h002}, 1'b0, 1'b0);
    step(1'b1, {PR_COORDX1, 12'h003}, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("clear_count", 32'(stb_c.size()), 32'd1);
    chk("clear_level", 32'(fifo_level_o), 32'd0);
    chk("clear_ovf", 32'(overflow_o), 32'd0);
    chk("clear_idle", 32'(idle_o), 32'd1);

    // Asynchronous reset in the middle of a draw
    step(1'b1, {PR_EXECUTE, PRIM_LINE}, 1'b0, 1'b0);
    step(1'b1, {PR_COORDX0, 12'h077}, 1'b0, 1'b0);
    repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, {PR_COORDY0, 12'h088}, 1'b0, 1'b1);
    #1;
    busy_r = 1'b0;
    host_if.valid = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1 reset_n_i = 1'b1;

    // Randomized traffic
    brun = 0;
    for (int i = 0; i < 3000; i++) begin
      if (brun > 0) brun--;
      else if ($urandom_range(15) == 0) brun = $urandom_range(30, 1);
      op = ($urandom_range(7) == 0) ? PR_EXECUTE : 4'($urandom);
      step($urandom_range(9) < 6, {op, 12'($urandom)}, $urandom_range(59) == 0, brun > 0);
    end
    repeat (50) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("drain", 32'(exq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
